// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/halt sequencing, tick prescaler and lap capture
// for an external two-digit BCD counter.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV    = 12000000,
    parameter int unsigned STOP_AT_MAX = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_stop_i,
    input  logic       clear_i,
    input  logic       lap_i,
    input  logic [3:0] digit_1_i,
    input  logic [3:0] digit_10_i,
    input  logic       carry_i,
    output logic       count_en_o,
    output logic       cnt_reset_o,
    output logic       running_o,
    output logic [3:0] lap_1_o,
    output logic [3:0] lap_10_o,
    output logic       lap_valid_o,
    output logic       overflow_o
);

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StRun,
        StPause,
        StHalt
    } state_e;

    localparam logic [23:0] PrescMax = 24'(TICK_DIV - 1);
    localparam bit          HaltAtMax = (STOP_AT_MAX != 0);

    state_e      state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic        count_en_q, count_en_d;
    logic        cnt_reset_q, cnt_reset_d;
    logic        running_q, running_d;
    logic [3:0]  lap_1_q, lap_1_d;
    logic [3:0]  lap_10_q, lap_10_d;
    logic        lap_valid_q, lap_valid_d;
    logic        overflow_q, overflow_d;

    logic wrap;
    logic at_max;
    logic lap_take;

    assign wrap     = (presc_q == PrescMax);
    assign at_max   = (digit_10_i == 4'd9) && (digit_1_i == 4'd9);
    assign lap_take = lap_i && !clear_i && ((state_q == StRun) || (state_q == StPause));

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        count_en_d  = 1'b0;
        overflow_d  = overflow_q;
        lap_1_d     = lap_1_q;
        lap_10_d    = lap_10_q;
        lap_valid_d = 1'b0;

        if (clear_i) begin
            state_d    = StClear;
            presc_d    = '0;
            overflow_d = 1'b0;
            lap_1_d    = '0;
            lap_10_d   = '0;
        end else begin
            case (state_q)
                StClear: begin
                    state_d  = StIdle;
                    presc_d  = '0;
                    lap_1_d  = '0;
                    lap_10_d = '0;
                end
                StIdle: begin
                    presc_d = '0;
                    if (start_stop_i) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    presc_d = wrap ? '0 : presc_q + 24'd1;
                    if (!HaltAtMax && carry_i) begin
                        overflow_d = 1'b1;
                    end
                    // Reaching 99 takes priority over a pause request in the same cycle.
                    if (wrap && HaltAtMax && at_max) begin
                        state_d = StHalt;
                    end else if (start_stop_i) begin
                        state_d = StPause;
                    end else begin
                        count_en_d = wrap;
                    end
                end
                StPause: begin
                    if (start_stop_i) begin
                        state_d = StRun;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StClear;
                end
            endcase

            if (lap_take) begin
                lap_1_d     = digit_1_i;
                lap_10_d    = digit_10_i;
                lap_valid_d = 1'b1;
            end
        end

        cnt_reset_d = (state_d == StClear);
        running_d   = (state_d == StRun);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StClear;
            presc_q     <= '0;
            count_en_q  <= 1'b0;
            cnt_reset_q <= 1'b1;
            running_q   <= 1'b0;
            lap_1_q     <= '0;
            lap_10_q    <= '0;
            lap_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            count_en_q  <= count_en_d;
            cnt_reset_q <= cnt_reset_d;
            running_q   <= running_d;
            lap_1_q     <= lap_1_d;
            lap_10_q    <= lap_10_d;
            lap_valid_q <= lap_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign count_en_o  = count_en_q;
    assign cnt_reset_o = cnt_reset_q;
    assign running_o   = running_q;
    assign lap_1_o     = lap_1_q;
    assign lap_10_o    = lap_10_q;
    assign lap_valid_o = lap_valid_q;
    assign overflow_o  = overflow_q;

endmodule
